scope_trigger_capture: RTL and testbench
========================================

Name: scope_trigger_capture

Overview:
Sits directly downstream of the ADC sampling stage in the oscilloscope datapath. It records 8-bit ADC samples into a circular RAM and detects a level/slope trigger. It freezes a window of DEPTH samples with PRE_DEPTH samples before the trigger. The display/readout stage then reads the frozen window by relative index, oldest sample first.

Parameters:
DATA_W, 8, ADC sample width
ADDR_W, 8, buffer address width; DEPTH = 2**ADDR_W
PRE_DEPTH, 64, samples kept before the trigger sample; legal range 1..DEPTH-1

Ports:
clk  in  1  system clock; the ADC clock domain is already re-timed to clk
rst  in  1  synchronous, active-high reset
sample_en  in  1  one-cycle strobe; addata is valid this cycle
addata  in  DATA_W  ADC sample
trig_level  in  DATA_W  trigger threshold, unsigned
trig_slope  in  1  0 = rising, 1 = falling
arm  in  1  pulse; starts or restarts a capture
force_trig  in  1  pulse; triggers regardless of level
rd_addr  in  ADDR_W  relative read index; 0 = oldest sample in the window
rd_data  out  DATA_W  registered read data
busy  out  1  high in PRE_FILL, WAIT_TRIG and POST_FILL
capture_done  out  1  high in DONE

Behaviour:
- Reset: state=IDLE; wr_ptr, cnt, start_addr, prev, force_pend, rd_data, busy and capture_done all 0. RAM contents are not cleared.
- States: IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, DONE.
- arm in any state: next state PRE_FILL; wr_ptr=0, cnt=0, force_pend=0. If sample_en is high in the same cycle, arm wins and that sample is dropped.
- Write rule: in PRE_FILL, WAIT_TRIG and POST_FILL, each sample_en writes mem[wr_ptr]<=addata, then wr_ptr<=wr_ptr+1 modulo DEPTH (wraps naturally). prev<=addata on every write.
- PRE_FILL: cnt counts written samples. When the write makes cnt reach PRE_DEPTH, go to WAIT_TRIG and clear cnt. Triggers and force_trig are ignored in this state.
- WAIT_TRIG trigger condition, evaluated only on a sample_en cycle:
  - rising: prev < trig_level and addata >= trig_level
  - falling: prev > trig_level and addata <= trig_level
  - force: force_trig is high this cycle, or force_pend is set
- force_trig in WAIT_TRIG with no sample_en sets force_pend.
- On trigger: the triggering sample is written. start_addr <= wr_ptr - PRE_DEPTH (mod DEPTH). Go to POST_FILL with cnt=0, force_pend=0.
- POST_FILL: each write increments cnt. The write that makes cnt = DEPTH-PRE_DEPTH-1 is the last one; the next state is DONE. capture_done rises the clock edge after that sample_en cycle.
- DONE: no writes; sample_en is ignored. Holds until arm or rst.
- Read port: rd_data <= mem[(start_addr + rd_addr) mod DEPTH], one-cycle latency, active in every state. Data is guaranteed only in DONE.
- Simultaneous sample_en and write-port read of the same address: read returns the old data (read-first).
- rst mid-capture: IDLE immediately; the partial capture is discarded and capture_done stays 0.
- Sampled values are unsigned; all pointer arithmetic is modulo DEPTH.
- Implementation: single inferred dual-port RAM, one write port and one read port.

Test Plan:
- Rising trigger, DEPTH=16, PRE_DEPTH=4, level=55, ramp 0,10,20,... one per 4 clk:
  - sample 6 (value 60) triggers and start_addr=2.
  - capture_done rises after sample 17.
  - rd_addr 0/4/15 -> rd_data 20/60/170, one cycle after the address is presented.
- Trigger in pre-fill ignored: falling slope, level=100, samples 200,50,200,50,200,50,... → the first trigger is sample 5 (200->50), not sample 1.
- force_trig in WAIT_TRIG between strobes with a constant input of 7 → the trigger is taken on the next sample_en; a window of 16 samples all equal to 7; capture_done asserted.
- Re-arm in POST_FILL with sample_en in the same cycle → busy stays 1, state is PRE_FILL, that sample is not written, and the capture restarts from wr_ptr=0.
- rst pulse during WAIT_TRIG → busy=0 and capture_done=0 next cycle; a subsequent arm plus the ramp scenario reproduces the first test's results.
- Wrap check: DEPTH=16, PRE_DEPTH=15, trigger at sample 20 → start_addr=5; rd_addr 15 returns the sample-20 value.

Source files
------------

// File: rtl/scope_trigger_capture.sv
// Oscilloscope capture buffer: records ADC samples into a circular RAM, detects a
// level/slope or forced trigger and freezes a DEPTH-sample window with PRE_DEPTH pre-trigger samples.
module scope_trigger_capture #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int PRE_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] addata,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              capture_done
);
  localparam int DEPTH    = 2**ADDR_W;
  localparam int POST_LEN = DEPTH - PRE_DEPTH - 1;
  localparam logic [ADDR_W-1:0] PRE_CNT  = ADDR_W'(PRE_DEPTH);
  localparam logic [ADDR_W-1:0] POST_CNT = ADDR_W'(POST_LEN);

  typedef enum logic [2:0] {IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_n, cnt, cnt_n, cnt_inc, start_addr, start_n;
  logic [DATA_W-1:0] prev;
  logic              force_pend, force_pend_n, we, trig, rising, falling;
  logic [DATA_W-1:0] mem [DEPTH];

  assign cnt_inc = cnt + 1'b1;
  assign rising  = (prev < trig_level) && (addata >= trig_level);
  assign falling = (prev > trig_level) && (addata <= trig_level);
  assign trig    = (trig_slope ? falling : rising) || force_trig || force_pend;

  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    cnt_n        = cnt;
    start_n      = start_addr;
    force_pend_n = force_pend;
    we           = 1'b0;
    if (arm) begin
      // arm takes priority over a coincident sample, which is dropped
      state_n      = PRE_FILL;
      wr_ptr_n     = '0;
      cnt_n        = '0;
      force_pend_n = 1'b0;
    end else begin
      case (state)
        PRE_FILL: if (sample_en) begin
          we       = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          cnt_n    = cnt_inc;
          if (cnt_inc == PRE_CNT) begin
            state_n = WAIT_TRIG;
            cnt_n   = '0;
          end
        end
        WAIT_TRIG: begin
          if (sample_en) begin
            we       = 1'b1;
            wr_ptr_n = wr_ptr + 1'b1;
            if (trig) begin
              start_n      = wr_ptr - PRE_CNT;
              cnt_n        = '0;
              force_pend_n = 1'b0;
              // with PRE_DEPTH = DEPTH-1 the trigger sample completes the window
              state_n      = (POST_LEN == 0) ? DONE : POST_FILL;
            end
          end else if (force_trig) begin
            force_pend_n = 1'b1;
          end
        end
        POST_FILL: if (sample_en) begin
          we       = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          cnt_n    = cnt_inc;
          if (cnt_inc == POST_CNT) state_n = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      cnt        <= '0;
      start_addr <= '0;
      prev       <= '0;
      force_pend <= 1'b0;
      rd_data    <= '0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      cnt        <= cnt_n;
      start_addr <= start_n;
      force_pend <= force_pend_n;
      if (we) prev <= addata;
      rd_data    <= mem[start_addr + rd_addr];
    end
  end

  // RAM array is never reset; read-first on address collision
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= addata;
  end

  assign busy         = (state == PRE_FILL) || (state == WAIT_TRIG) || (state == POST_FILL);
  assign capture_done = (state == DONE);
endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture: DEPTH=16 with PRE_DEPTH=4 (dut_a) and 15 (dut_b).
module tb_scope_trigger_capture;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_en = 1'b0;
  logic [7:0] addata = '0;
  logic [7:0] trig_level = 8'd55;
  logic       trig_slope = 1'b0;
  logic       arm = 1'b0;
  logic       force_trig = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data_a, rd_data_b;
  logic       busy_a, busy_b, done_a, done_b;
  int         pass_cnt = 0;
  int         total = 0;

  always #5 clk = ~clk;

  scope_trigger_capture #(.DATA_W(8), .ADDR_W(4), .PRE_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .sample_en(sample_en), .addata(addata),
    .trig_level(trig_level), .trig_slope(trig_slope), .arm(arm), .force_trig(force_trig),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .busy(busy_a), .capture_done(done_a));

  scope_trigger_capture #(.DATA_W(8), .ADDR_W(4), .PRE_DEPTH(15)) dut_b (
    .clk(clk), .rst(rst), .sample_en(sample_en), .addata(addata),
    .trig_level(trig_level), .trig_slope(trig_slope), .arm(arm), .force_trig(force_trig),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .busy(busy_b), .capture_done(done_b));

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic smp(input logic [7:0] v);
    sample_en = 1'b1; addata = v; tick(1);
    sample_en = 1'b0; tick(3);
  endtask

  task automatic ramp(input int first, input int last);
    for (int i = first; i <= last; i++) smp(8'(10 * i));
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(1); arm = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a; tick(1); chk(tag, rd_data_a, exp);
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_rd_data", rd_data_a, 0);
    chk("rst_wr_ptr", dut_a.wr_ptr, 0);

    // rising trigger on a ramp
    trig_level = 8'd55; trig_slope = 1'b0;
    do_arm();
    chk("arm_busy", busy_a, 1);
    ramp(0, 5);
    chk("wait_busy", busy_a, 1);
    chk("no_trig_yet", dut_a.start_addr, 0);
    smp(8'd60);
    chk("rise_start_addr", dut_a.start_addr, 2);
    ramp(7, 16);
    chk("post_not_done", done_a, 0);
    sample_en = 1'b1; addata = 8'd170; tick(1); sample_en = 1'b0;
    chk("done_after_s17", done_a, 1);
    chk("done_busy", busy_a, 0);
    tick(3);
    smp(8'd250);
    rd_a("ramp_rd0", 4'd0, 8'd20);
    rd_a("ramp_rd4", 4'd4, 8'd60);
    rd_a("ramp_rd15", 4'd15, 8'd170);

    // falling slope: pre-fill crossings ignored
    trig_level = 8'd100; trig_slope = 1'b1;
    do_arm();
    for (int i = 0; i < 5; i++) smp((i % 2 == 0) ? 8'd200 : 8'd50);
    chk("fall_no_early_trig", dut_a.start_addr, 2);
    smp(8'd50);
    chk("fall_start_addr", dut_a.start_addr, 1);
    for (int i = 6; i <= 16; i++) smp((i % 2 == 0) ? 8'd200 : 8'd50);
    chk("fall_done", done_a, 1);
    rd_a("fall_rd4", 4'd4, 8'd50);
    rd_a("fall_rd3", 4'd3, 8'd200);

    // force trigger between strobes
    trig_level = 8'd255; trig_slope = 1'b0;
    do_arm();
    for (int i = 0; i < 6; i++) smp(8'd7);
    chk("const_no_trig", dut_a.start_addr, 1);
    force_trig = 1'b1; tick(1); force_trig = 1'b0;
    chk("force_pend", dut_a.force_pend, 1);
    chk("force_busy", busy_a, 1);
    smp(8'd7);
    chk("force_start_addr", dut_a.start_addr, 2);
    chk("force_pend_clr", dut_a.force_pend, 0);
    for (int i = 0; i < 11; i++) smp(8'd7);
    chk("force_done", done_a, 1);
    for (int i = 0; i < 16; i++) rd_a("force_rd", 4'(i), 8'd7);

    // re-arm during POST_FILL with a coincident sample
    trig_level = 8'd55; trig_slope = 1'b0;
    do_arm();
    ramp(0, 8);
    sample_en = 1'b1; addata = 8'd99; arm = 1'b1; tick(1);
    sample_en = 1'b0; arm = 1'b0;
    chk("rearm_busy", busy_a, 1);
    chk("rearm_state", dut_a.state, 1);
    chk("rearm_wr_ptr", dut_a.wr_ptr, 0);
    chk("rearm_cnt", dut_a.cnt, 0);
    chk("rearm_dropped", dut_a.mem[9], 7);

    // reset during WAIT_TRIG, then rerun the ramp
    ramp(0, 4);
    chk("pre_rst_busy", busy_a, 1);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("rst_mid_busy", busy_a, 0);
    chk("rst_mid_done", done_a, 0);
    tick(2);
    chk("rst_stays_idle", done_a, 0);
    do_arm();
    ramp(0, 17);
    chk("rerun_done", done_a, 1);
    rd_a("rerun_rd0", 4'd0, 8'd20);
    rd_a("rerun_rd4", 4'd4, 8'd60);
    rd_a("rerun_rd15", 4'd15, 8'd170);

    // wrap: PRE_DEPTH=15, trigger at sample 20
    trig_level = 8'd195; trig_slope = 1'b0;
    do_arm();
    ramp(0, 19);
    chk("wrap_not_done", done_b, 0);
    chk("wrap_busy", busy_b, 1);
    smp(8'd200);
    chk("wrap_done", done_b, 1);
    chk("wrap_start_addr", dut_b.start_addr, 5);
    rd_addr = 4'd15; tick(1); chk("wrap_rd15", rd_data_b, 200);
    rd_addr = 4'd0;  tick(1); chk("wrap_rd0", rd_data_b, 50);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
